// File: rtl/vga_sdram_rd_ctrl_if.sv
// SDRAM read-request channel between the VGA frame reader and the SDRAM controller.
// master = frame reader, slave = SDRAM controller.
interface vga_sdram_rd_ctrl_if;
  logic        rd_req;
  logic [1:0]  rd_bank_o;
  logic [21:0] rd_add_o;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;

  modport master (
    output rd_req, rd_bank_o, rd_add_o,
    input  rd_ack, rd_valid, rd_data
  );

  modport slave (
    input  rd_req, rd_bank_o, rd_add_o,
    output rd_ack, rd_valid, rd_data
  );
endinterface

// File: rtl/vga_sdram_rd_ctrl.sv
// VGA-side SDRAM frame reader: streams one frame per VGA frame start into the VGA FIFO.
// Optional macro VGA_RD_LATE_CNT_EN adds a saturating late_cnt[15:0] output.
module vga_sdram_rd_ctrl #(
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned FIFO_LOW    = 512,
  parameter int unsigned FIFO_AW     = 10
) (
  input  logic               clk,
  input  logic               rst_133,
  input  logic               vga_vs,
  input  logic [1:0]         vga_bank,
  input  logic [FIFO_AW-1:0] fifo_usedw,
  vga_sdram_rd_ctrl_if.master rd,
  output logic               fifo_wr,
  output logic [15:0]        fifo_din,
  output logic               vga_rise,
  output logic               frame_done,
`ifdef VGA_RD_LATE_CNT_EN
  output logic [15:0]        late_cnt,
`endif
  output logic               late_frame
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [21:0]   BL   = 22'(BURST_LEN);
  localparam logic [21:0]   FW   = 22'(FRAME_WORDS);
  localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    WAIT_FRAME,
    CHECK,
    REQ,
    BURST,
    DONE
  } state_e;

  state_e      state_q;
  logic        vs_s1_q;
  logic        vs_s2_q;
  logic        vs_s3_q;
  logic        rd_req_q;
  logic [1:0]  bank_q;
  logic [21:0] add_q;
  logic [21:0] left_q;
  logic [BW-1:0] beat_q;
  logic        fifo_wr_q;
  logic [15:0] din_q;
  logic        rise_q;
  logic        done_q;
  logic        late_q;
  logic        pend_q;

  logic fs;
  logic busy;
  logic fifo_low;

  assign fs       = vs_s2_q & ~vs_s3_q;
  assign busy     = (state_q != WAIT_FRAME);
  assign fifo_low = (32'(fifo_usedw) < FIFO_LOW);

  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      state_q   <= WAIT_FRAME;
      vs_s1_q   <= 1'b0;
      vs_s2_q   <= 1'b0;
      vs_s3_q   <= 1'b0;
      rd_req_q  <= 1'b0;
      bank_q    <= 2'b00;
      add_q     <= 22'd0;
      left_q    <= 22'd0;
      beat_q    <= '0;
      fifo_wr_q <= 1'b0;
      din_q     <= 16'd0;
      rise_q    <= 1'b0;
      done_q    <= 1'b0;
      late_q    <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      vs_s1_q   <= vga_vs;
      vs_s2_q   <= vs_s1_q;
      vs_s3_q   <= vs_s2_q;
      fifo_wr_q <= 1'b0;
      done_q    <= 1'b0;
      if (fs && busy) begin
        late_q <= 1'b1;
        pend_q <= 1'b1;
      end
      unique case (state_q)
        WAIT_FRAME: if (fs || pend_q) begin
          bank_q  <= vga_bank;
          add_q   <= 22'd0;
          left_q  <= FW;
          rise_q  <= 1'b1;
          pend_q  <= 1'b0;
          state_q <= CHECK;
        end
        // a pending frame start restarts the same frame; vga_rise stays high
        CHECK: if (fs || pend_q) begin
          bank_q  <= vga_bank;
          add_q   <= 22'd0;
          left_q  <= FW;
          pend_q  <= 1'b0;
        end else if (fifo_low) begin
          rd_req_q <= 1'b1;
          state_q  <= REQ;
        end
        REQ: if (rd.rd_ack) begin
          rd_req_q <= 1'b0;
          beat_q   <= '0;
          state_q  <= BURST;
        end
        BURST: if (rd.rd_valid) begin
          fifo_wr_q <= 1'b1;
          din_q     <= rd.rd_data;
          beat_q    <= beat_q + 1'b1;
          if (beat_q == LAST) begin
            add_q   <= add_q + BL;
            left_q  <= left_q - BL;
            state_q <= (left_q == BL) ? DONE : CHECK;
          end
        end
        DONE: begin
          rise_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= WAIT_FRAME;
        end
        default: state_q <= WAIT_FRAME;
      endcase
    end
  end

`ifdef VGA_RD_LATE_CNT_EN
  logic [15:0] late_cnt_q;

  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      late_cnt_q <= 16'd0;
    end else if (fs && busy && late_cnt_q != 16'hFFFF) begin
      late_cnt_q <= late_cnt_q + 16'd1;
    end
  end

  assign late_cnt = late_cnt_q;
`endif

  assign rd.rd_req    = rd_req_q;
  assign rd.rd_bank_o = bank_q;
  assign rd.rd_add_o  = add_q;
  assign fifo_wr      = fifo_wr_q;
  assign fifo_din     = din_q;
  assign vga_rise     = rise_q;
  assign frame_done   = done_q;
  assign late_frame   = late_q;

endmodule

// File: tb/tb_vga_sdram_rd_ctrl.sv
// Bench for vga_sdram_rd_ctrl: random SDRAM responder and FIFO scoreboard,
// directed frame scenarios checked against a frame-level request model.
`define CHK(tag, o, e) begin checks++; assert ((o) === (e)) else begin errors++; $error("FAIL %s obs=%0h exp=%0h", tag, (o), (e)); end end

module tb_vga_sdram_rd_ctrl;
  localparam int BL = 4;
  localparam int FW = 16;
  localparam int FL = 8;
  localparam int AW = 4;
  localparam int NB = FW / BL;

  logic          clk = 1'b0;
  logic          rst_133;
  logic          vga_vs;
  logic [1:0]    vga_bank;
  logic [AW-1:0] fifo_usedw;
  logic          fifo_wr;
  logic [15:0]   fifo_din;
  logic          vga_rise;
  logic          frame_done;
  logic          late_frame;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [23:0] req_log[$];
  logic [23:0] exp_log[$];

  int   ack_min = 0;
  bit   ack_rand = 1'b1;
  bit   resp_busy = 1'b0;
  bit   in_beats = 1'b0;
  logic [15:0] d;

  int   wr_cnt = 0;
  int   fall_cnt = 0;
  int   wr_base = 0;
  int   fall_base = 0;
  logic prev_rise = 1'b0;
  logic prev_req = 1'b0;
  logic [AW-1:0] prev_usedw = '0;
  logic [15:0] mon_exp;

  vga_sdram_rd_ctrl_if rif();

  vga_sdram_rd_ctrl #(
    .BURST_LEN(BL),
    .FRAME_WORDS(FW),
    .FIFO_LOW(FL),
    .FIFO_AW(AW)
  ) dut (
    .clk(clk),
    .rst_133(rst_133),
    .vga_vs(vga_vs),
    .vga_bank(vga_bank),
    .fifo_usedw(fifo_usedw),
    .rd(rif),
    .fifo_wr(fifo_wr),
    .fifo_din(fifo_din),
    .vga_rise(vga_rise),
    .frame_done(frame_done),
    .late_frame(late_frame)
  );

  initial forever #5 clk = ~clk;

  // SDRAM controller model: ack after a delay, then BL beats with random gaps
  initial begin : sdram
    rif.rd_ack   = 1'b0;
    rif.rd_valid = 1'b0;
    rif.rd_data  = 16'd0;
    forever begin
      @(posedge clk); #1;
      if (rst_133 && rif.rd_req) begin
        resp_busy = 1'b1;
        req_log.push_back({rif.rd_bank_o, rif.rd_add_o});
        repeat (ack_min + (ack_rand ? int'($urandom_range(3, 0)) : 0)) begin
          @(posedge clk); #1;
        end
        rif.rd_ack = 1'b1;
        @(posedge clk); #1;
        rif.rd_ack = 1'b0;
        in_beats = 1'b1;
        for (int i = 0; i < BL; i++) begin
          repeat ($urandom_range(2, 0)) begin
            @(posedge clk); #1;
          end
          d = 16'($urandom);
          rif.rd_valid = 1'b1;
          rif.rd_data  = d;
          exp_q.push_back(d);
          @(posedge clk); #1;
          rif.rd_valid = 1'b0;
        end
        in_beats  = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  task automatic sample();
    if (rst_133) begin
      if (fifo_wr) begin
        wr_cnt++;
        `CHK("wr_expected", (exp_q.size() != 0), 1'b1)
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          `CHK("wr_data", fifo_din, mon_exp)
        end
      end
      if (rif.rd_req && !prev_req)
        `CHK("req_usedw_low", (prev_usedw < AW'(FL)), 1'b1)
      if (prev_rise && !vga_rise) fall_cnt++;
    end
    prev_req   = rif.rd_req;
    prev_rise  = vga_rise;
    prev_usedw = fifo_usedw;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk); #2;
  endtask

  task automatic start_frame(input logic [1:0] b);
    vga_vs = 1'b0;
    repeat (4) tick();
    vga_bank = b;
    req_log.delete();
    wr_base   = wr_cnt;
    fall_base = fall_cnt;
    vga_vs = 1'b1;
  endtask

  task automatic add_frame(input logic [1:0] b, input int nbursts);
    for (int k = 0; k < nbursts; k++) exp_log.push_back({b, 22'(k * BL)});
  endtask

  task automatic check_log(input string tag);
    `CHK({tag, "_nreq"}, req_log.size(), exp_log.size())
    for (int k = 0; k < exp_log.size() && k < req_log.size(); k++)
      `CHK({tag, "_req"}, req_log[k], exp_log[k])
    exp_log.delete();
  endtask

  task automatic wait_done(input int bound, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (rnd) fifo_usedw = AW'($urandom_range(15, 0));
      tick();
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin : main
    bit ok;
    bit seen;
    int n;
    int bad;
    logic [1:0] b;

    rst_133    = 1'b0;
    vga_vs     = 1'b0;
    vga_bank   = 2'b10;
    fifo_usedw = '0;
    repeat (3) tick();
    `CHK("rst_req", rif.rd_req, 1'b0)
    `CHK("rst_bank", rif.rd_bank_o, 2'b00)
    `CHK("rst_add", rif.rd_add_o, 22'd0)
    `CHK("rst_wr", fifo_wr, 1'b0)
    `CHK("rst_din", fifo_din, 16'd0)
    `CHK("rst_rise", vga_rise, 1'b0)
    `CHK("rst_done", frame_done, 1'b0)
    `CHK("rst_late", late_frame, 1'b0)
    rst_133 = 1'b1;
    repeat (2) tick();

    // plain frame on bank 2
    start_frame(2'b10);
    add_frame(2'b10, NB);
    wait_done(400, 1'b0, ok);
    `CHK("t1_done", ok, 1'b1)
    `CHK("t1_rise_low", vga_rise, 1'b0)
    tick();
    `CHK("t1_done_pulse", frame_done, 1'b0)
    `CHK("t1_writes", wr_cnt - wr_base, FW)
    `CHK("t1_falls", fall_cnt - fall_base, 1)
    `CHK("t1_q_empty", exp_q.size(), 0)
    check_log("t1");

    // throttling, delayed ack, bank change mid-frame
    fifo_usedw = 4'd9;
    ack_min  = 20;
    ack_rand = 1'b0;
    start_frame(2'b00);
    add_frame(2'b00, NB);
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (rif.rd_req) seen = 1'b1;
    end
    `CHK("t2_throttled", seen, 1'b0)
    `CHK("t2_rise", vga_rise, 1'b1)
    fifo_usedw = 4'd7;
    n = 0;
    while (!rif.rd_req && n < 2) begin
      tick();
      n++;
    end
    `CHK("t2_req_rise", rif.rd_req, 1'b1)
    n = 0;
    bad = 0;
    while (!rif.rd_ack && n < 40) begin
      if (rif.rd_req !== 1'b1 || rif.rd_add_o !== 22'd0) bad++;
      tick();
      n++;
    end
    `CHK("t3_stable", bad, 0)
    `CHK("t3_ack_delay", (n >= 20 && n < 40), 1'b1)
    `CHK("t3_req_at_ack", rif.rd_req, 1'b1)
    ack_min  = 0;
    ack_rand = 1'b1;
    tick();
    `CHK("t3_req_fall", rif.rd_req, 1'b0)
    vga_bank = 2'b01;
    wait_done(600, 1'b0, ok);
    `CHK("t5_done", ok, 1'b1)
    `CHK("t5_bank_held", rif.rd_bank_o, 2'b00)
    tick();
    `CHK("t5_writes", wr_cnt - wr_base, FW)
    `CHK("t5_q_empty", exp_q.size(), 0)
    check_log("t5");

    // frame start during the second burst
    fifo_usedw = '0;
    ack_min = 5;
    start_frame(2'b01);
    n = 0;
    while (req_log.size() < 1 && n < 100) begin
      tick();
      n++;
    end
    vga_vs = 1'b0;
    while (req_log.size() < 2 && n < 200) begin
      tick();
      n++;
    end
    `CHK("t4_second_req", req_log.size(), 2)
    vga_vs = 1'b1;
    wait_done(800, 1'b0, ok);
    `CHK("t4_done", ok, 1'b1)
    tick();
    `CHK("t4_late", late_frame, 1'b1)
    `CHK("t4_falls", fall_cnt - fall_base, 1)
    `CHK("t4_writes", wr_cnt - wr_base, FW + 2 * BL)
    `CHK("t4_q_empty", exp_q.size(), 0)
    add_frame(2'b01, 2);
    add_frame(2'b01, NB);
    check_log("t4");
    ack_min = 0;

    // asynchronous reset in the middle of a burst
    start_frame(2'b11);
    n = 0;
    while (!in_beats && n < 200) begin
      tick();
      n++;
    end
    `CHK("t6_in_burst", in_beats, 1'b1)
    `CHK("t6_rise_pre", vga_rise, 1'b1)
    `CHK("t6_bank_pre", rif.rd_bank_o, 2'b11)
    rst_133 = 1'b0;
    #1;
    `CHK("t6_req", rif.rd_req, 1'b0)
    `CHK("t6_bank", rif.rd_bank_o, 2'b00)
    `CHK("t6_add", rif.rd_add_o, 22'd0)
    `CHK("t6_wr", fifo_wr, 1'b0)
    `CHK("t6_din", fifo_din, 16'd0)
    `CHK("t6_rise", vga_rise, 1'b0)
    `CHK("t6_done", frame_done, 1'b0)
    `CHK("t6_late", late_frame, 1'b0)
    vga_vs = 1'b0;
    n = 0;
    while (resp_busy && n < 50) begin
      tick();
      n++;
    end
    `CHK("t6_resp_idle", resp_busy, 1'b0)
    exp_q.delete();
    repeat (2) tick();
    rst_133 = 1'b1;
    repeat (2) tick();

    // random banks and random FIFO fill levels
    for (int f = 0; f < 3; f++) begin
      b = 2'($urandom);
      start_frame(b);
      add_frame(b, NB);
      wait_done(2000, 1'b1, ok);
      fifo_usedw = '0;
      `CHK("rnd_done", ok, 1'b1)
      `CHK("rnd_rise_low", vga_rise, 1'b0)
      tick();
      `CHK("rnd_done_pulse", frame_done, 1'b0)
      `CHK("rnd_writes", wr_cnt - wr_base, FW)
      `CHK("rnd_falls", fall_cnt - fall_base, 1)
      `CHK("rnd_q_empty", exp_q.size(), 0)
      check_log("rnd");
    end
    `CHK("rnd_no_late", late_frame, 1'b0)

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
